// File: rtl/ssg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ssg_scan_ctrl
// Brief   : 4-digit multiplexed 7-segment scanner with blanking gap, BCD decode,
//           leading-zero suppression and frame-aligned req/ack digit capture.
// Revision: 1.0 - initial release
// ============================================================================
module ssg_scan_ctrl #(
  parameter int BLANK_TICKS = 4,
  parameter int DRIVE_TICKS = 50000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        frame_done,
  output logic [6:0]  SSG_D,
  output logic        SSG_DP,
  output logic [3:0]  SSG_EN
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] C_DRIVE_LAST = CNT_W'(DRIVE_TICKS - 1);
  localparam logic [6:0]       C_SEG_OFF    = 7'b1111111;

  logic [0:0]       r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_presc;
  logic [15:0]      r_digits;
  logic [3:0]       r_dp;
  logic             r_ack;
  logic             r_frame_done;
  logic [6:0]       r_ssg_d;
  logic             r_ssg_dp;
  logic [3:0]       r_ssg_en;

  logic [0:0]       w_nxt_state;
  logic [1:0]       w_nxt_idx;
  logic [CNT_W-1:0] w_nxt_presc;
  logic             w_blank_last;
  logic             w_drive_last;
  logic             w_boundary;
  logic [3:0]       w_zero;
  logic [3:0]       w_sup;
  logic [3:0]       w_nib;
  logic [3:0]       w_en_nxt;
  logic [6:0]       w_d_nxt;
  logic             w_dp_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = C_SEG_OFF;
    endcase
  endfunction

  always_comb begin
    w_blank_last = (r_state == ST_BLANK) && (r_presc == C_BLANK_LAST);
    w_drive_last = (r_state == ST_DRIVE) && (r_presc == C_DRIVE_LAST);
    w_boundary   = w_drive_last && (r_idx == 2'd3);
    w_nxt_state  = r_state;
    w_nxt_idx    = r_idx;
    w_nxt_presc  = r_presc + CNT_W'(1);
    if (w_blank_last) begin
      w_nxt_state = ST_DRIVE;
      w_nxt_presc = '0;
    end else if (w_drive_last) begin
      w_nxt_state = ST_BLANK;
      w_nxt_idx   = r_idx + 2'd1;
      w_nxt_presc = '0;
    end
  end

  // A digit is suppressed only while every digit above it is also suppressed;
  // a lit DP breaks the chain for itself and everything below.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_zero[i] = (r_digits[i*4 +: 4] == 4'd0);
    end
    w_sup[3] = lz_en & w_zero[3] & ~r_dp[3];
    w_sup[2] = w_sup[3] & w_zero[2] & ~r_dp[2];
    w_sup[1] = w_sup[2] & w_zero[1] & ~r_dp[1];
    w_sup[0] = 1'b0;
  end

  // Outputs are built from the next state so the pins line up with the state.
  // Shadow only changes on entry to BLANK, so the current shadow is correct here.
  always_comb begin
    w_nib    = r_digits[{w_nxt_idx, 2'b00} +: 4];
    w_en_nxt = 4'b1111;
    w_d_nxt  = C_SEG_OFF;
    w_dp_nxt = 1'b1;
    if (w_nxt_state == ST_DRIVE) begin
      w_en_nxt[w_nxt_idx] = 1'b0;
      w_d_nxt             = w_sup[w_nxt_idx] ? C_SEG_OFF : f_decode(w_nib);
      w_dp_nxt            = ~r_dp[w_nxt_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_BLANK;
      r_idx        <= 2'd0;
      r_presc      <= '0;
      r_digits     <= 16'h0000;
      r_dp         <= 4'h0;
      r_ack        <= 1'b0;
      r_frame_done <= 1'b0;
      r_ssg_d      <= C_SEG_OFF;
      r_ssg_dp     <= 1'b1;
      r_ssg_en     <= 4'b1111;
    end else begin
      r_state      <= w_nxt_state;
      r_idx        <= w_nxt_idx;
      r_presc      <= w_nxt_presc;
      r_frame_done <= w_boundary;
      r_ack        <= w_boundary & upd_req;
      r_ssg_d      <= w_d_nxt;
      r_ssg_dp     <= w_dp_nxt;
      r_ssg_en     <= w_en_nxt;
      if (w_boundary && upd_req) begin
        r_digits <= digits_in;
        r_dp     <= dp_in;
      end
    end
  end

  assign upd_ack    = r_ack;
  assign frame_done = r_frame_done;
  assign SSG_D      = r_ssg_d;
  assign SSG_DP     = r_ssg_dp;
  assign SSG_EN     = r_ssg_en;

endmodule
`default_nettype wire

// File: tb/tb_ssg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ssg_scan_ctrl
// Brief   : Directed self-checking bench for ssg_scan_ctrl (BLANK=2, DRIVE=5).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ssg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic        upd_req = 1'b0;
  logic        upd_ack;
  logic        frame_done;
  logic [6:0]  SSG_D;
  logic        SSG_DP;
  logic [3:0]  SSG_EN;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  ssg_scan_ctrl #(
    .BLANK_TICKS(2),
    .DRIVE_TICKS(5),
    .CNT_W      (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .frame_done(frame_done),
    .SSG_D     (SSG_D),
    .SSG_DP    (SSG_DP),
    .SSG_EN    (SSG_EN)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // n counts cycles since reset release; frame position is n % 28
  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  task automatic wait_phase(input int p);
    tick();
    while ((n % 28) != p) tick();
  endtask

  task automatic test_reset();
    logic [3:0] e_en;
    logic [6:0] e_d;
    int p;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (SSG_EN !== 4'b1111) begin miscompares++; $display("FAIL rst_en: got %b want 1111", SSG_EN); end
    vectors++; if (SSG_D !== 7'b1111111) begin miscompares++; $display("FAIL rst_d: got %b want 1111111", SSG_D); end
    vectors++; if (SSG_DP !== 1'b1) begin miscompares++; $display("FAIL rst_dp: got %b want 1", SSG_DP); end
    vectors++; if (upd_ack !== 1'b0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_pulses: got ack=%b fd=%b want 0/0", upd_ack, frame_done); end
    reset = 1'b0;
    n = 0;
    for (int k = 0; k <= 28; k++) begin
      p = n % 28;
      e_en = 4'b1111;
      e_d  = 7'b1111111;
      if ((p % 7) >= 2) begin
        e_en[p / 7] = 1'b0;
        e_d = 7'b1000000;
      end
      vectors++; if (SSG_EN !== e_en) begin miscompares++; $display("FAIL scan_en n=%0d: got %b want %b", n, SSG_EN, e_en); end
      vectors++; if (SSG_D !== e_d) begin miscompares++; $display("FAIL scan_d n=%0d: got %b want %b", n, SSG_D, e_d); end
      vectors++; if (frame_done !== (n == 28)) begin miscompares++; $display("FAIL scan_fd n=%0d: got %b want %b", n, frame_done, (n == 28)); end
      vectors++; if (upd_ack !== 1'b0) begin miscompares++; $display("FAIL scan_ack n=%0d: got %b want 0", n, upd_ack); end
      if (k < 28) tick();
    end
  endtask

  task automatic test_digits();
    logic [6:0] exp_d [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    logic [3:0] e_en;
    digits_in = 16'h1234;
    dp_in = 4'h0;
    wait_phase(10);
    upd_req = 1'b1;
    wait_phase(27);
    vectors++; if (upd_ack !== 1'b0) begin miscompares++; $display("FAIL dig_early_ack: got %b want 0", upd_ack); end
    tick();
    vectors++; if (frame_done !== 1'b1 || upd_ack !== 1'b1) begin miscompares++; $display("FAIL dig_ack: got fd=%b ack=%b want 1/1", frame_done, upd_ack); end
    upd_req = 1'b0;
    tick();
    vectors++; if (upd_ack !== 1'b0) begin miscompares++; $display("FAIL dig_ack_width: got %b want 0", upd_ack); end
    for (int d = 0; d < 4; d++) begin
      wait_phase(d * 7 + 4);
      e_en = ~(4'b0001 << d);
      vectors++; if (SSG_EN !== e_en) begin miscompares++; $display("FAIL dig_en%0d: got %b want %b", d, SSG_EN, e_en); end
      vectors++; if (SSG_D !== exp_d[d]) begin miscompares++; $display("FAIL dig_d%0d: got %b want %b", d, SSG_D, exp_d[d]); end
      vectors++; if (SSG_DP !== 1'b1) begin miscompares++; $display("FAIL dig_dp%0d: got %b want 1", d, SSG_DP); end
    end
    wait_phase(0);
    vectors++; if (frame_done !== 1'b1 || upd_ack !== 1'b0) begin miscompares++; $display("FAIL dig_noreq: got fd=%b ack=%b want 1/0", frame_done, upd_ack); end
  endtask

  task automatic test_midframe();
    wait_phase(3);
    digits_in = 16'h9999;
    wait_phase(11);
    vectors++; if (SSG_EN !== 4'b1101 || SSG_D !== 7'b0110000) begin miscompares++; $display("FAIL mid_hold: got en=%b d=%b want 1101/0110000", SSG_EN, SSG_D); end
    wait_phase(0);
    vectors++; if (upd_ack !== 1'b0) begin miscompares++; $display("FAIL mid_noack: got %b want 0", upd_ack); end
    wait_phase(4);
    vectors++; if (SSG_D !== 7'b0011001) begin miscompares++; $display("FAIL mid_old0: got %b want 0011001", SSG_D); end
    wait_phase(10);
    upd_req = 1'b1;
    wait_phase(18);
    vectors++; if (SSG_D !== 7'b0100100 || upd_ack !== 1'b0) begin miscompares++; $display("FAIL mid_req_old: got d=%b ack=%b want 0100100/0", SSG_D, upd_ack); end
    wait_phase(0);
    vectors++; if (upd_ack !== 1'b1 || frame_done !== 1'b1) begin miscompares++; $display("FAIL mid_ack: got ack=%b fd=%b want 1/1", upd_ack, frame_done); end
    upd_req = 1'b0;
    wait_phase(4);
    vectors++; if (SSG_D !== 7'b0010000) begin miscompares++; $display("FAIL mid_new0: got %b want 0010000", SSG_D); end
    wait_phase(25);
    vectors++; if (SSG_EN !== 4'b0111 || SSG_D !== 7'b0010000) begin miscompares++; $display("FAIL mid_new3: got en=%b d=%b want 0111/0010000", SSG_EN, SSG_D); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] lz_on  [4] = '{7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111};
    logic [6:0] lz_off [4] = '{7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000};
    logic [6:0] lz_dp  [4] = '{7'b1000000, 7'b1111000, 7'b1000000, 7'b1111111};
    logic       dp_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    digits_in = 16'h0070;
    dp_in = 4'h0;
    lz_en = 1'b1;
    upd_req = 1'b1;
    wait_phase(0);
    vectors++; if (upd_ack !== 1'b1) begin miscompares++; $display("FAIL lz_ack: got %b want 1", upd_ack); end
    upd_req = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_phase(d * 7 + 4);
      vectors++; if (SSG_D !== lz_on[d]) begin miscompares++; $display("FAIL lz_on_d%0d: got %b want %b", d, SSG_D, lz_on[d]); end
    end
    lz_en = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_phase(d * 7 + 4);
      vectors++; if (SSG_D !== lz_off[d]) begin miscompares++; $display("FAIL lz_off_d%0d: got %b want %b", d, SSG_D, lz_off[d]); end
    end
    lz_en = 1'b1;
    dp_in = 4'b0100;
    upd_req = 1'b1;
    wait_phase(0);
    upd_req = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_phase(d * 7 + 4);
      vectors++; if (SSG_D !== lz_dp[d] || SSG_DP !== dp_exp[d]) begin miscompares++; $display("FAIL lz_dp_d%0d: got d=%b dp=%b want %b/%b", d, SSG_D, SSG_DP, lz_dp[d], dp_exp[d]); end
    end
  endtask

  task automatic test_non_bcd();
    logic [6:0] exp_d  [4] = '{7'b0010010, 7'b1111111, 7'b1000000, 7'b1000000};
    logic       exp_dp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    lz_en = 1'b0;
    digits_in = 16'h00A5;
    dp_in = 4'b0010;
    upd_req = 1'b1;
    wait_phase(0);
    upd_req = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_phase(d * 7 + 4);
      vectors++; if (SSG_D !== exp_d[d] || SSG_DP !== exp_dp[d]) begin miscompares++; $display("FAIL nbcd_d%0d: got d=%b dp=%b want %b/%b", d, SSG_D, SSG_DP, exp_d[d], exp_dp[d]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e_en;
    logic [6:0] e_d;
    int p;
    digits_in = 16'h8888;
    dp_in = 4'h0;
    upd_req = 1'b1;
    wait_phase(18);
    vectors++; if (SSG_EN !== 4'b1011) begin miscompares++; $display("FAIL rmid_pre_en: got %b want 1011", SSG_EN); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (SSG_EN !== 4'b1111 || SSG_D !== 7'b1111111 || SSG_DP !== 1'b1) begin miscompares++; $display("FAIL rmid_dark: got en=%b d=%b dp=%b want 1111/1111111/1", SSG_EN, SSG_D, SSG_DP); end
    repeat (2) @(negedge clk);
    vectors++; if (upd_ack !== 1'b0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL rmid_pulses: got ack=%b fd=%b want 0/0", upd_ack, frame_done); end
    reset = 1'b0;
    upd_req = 1'b0;
    n = 0;
    for (int k = 0; k <= 28; k++) begin
      p = n % 28;
      e_en = 4'b1111;
      e_d  = 7'b1111111;
      if ((p % 7) >= 2) begin
        e_en[p / 7] = 1'b0;
        e_d = 7'b1000000;
      end
      vectors++; if (SSG_EN !== e_en || SSG_D !== e_d) begin miscompares++; $display("FAIL rmid_scan n=%0d: got en=%b d=%b want %b/%b", n, SSG_EN, SSG_D, e_en, e_d); end
      vectors++; if (frame_done !== (n == 28) || upd_ack !== 1'b0) begin miscompares++; $display("FAIL rmid_pulse n=%0d: got fd=%b ack=%b want %b/0", n, frame_done, upd_ack, (n == 28)); end
      if (k < 28) tick();
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_midframe();
    test_leading_zero();
    test_non_bcd();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
